// File: rtl/fetch_pkg.sv
// Shared fetch front-end types and constants, also used by branch presolve and icache.
package fetch_pkg;

   localparam int unsigned FETCH_GROUP_BYTES = 8;
   localparam int unsigned FETCH_ALIGN_BITS  = 3;

   typedef logic [63:0] pc_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   function automatic pc_t fetch_align(input pc_t pc);
      return {pc[63:FETCH_ALIGN_BITS], {FETCH_ALIGN_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Redirect inputs and icache fetch request handshake of the fetch PC generator.
interface fetch_pc_gen_if;
   import fetch_pkg::*;

   logic io_i_backend_redirect_valid;
   pc_t  io_i_backend_redirect_target;
   logic io_i_branch_presolve_pack_valid;
   pc_t  io_i_branch_presolve_pack_pc;
   logic io_i_fetch_req_ready;
   logic io_o_fetch_req_valid;
   pc_t  io_o_fetch_req_pc;
   logic io_o_flush;

   modport master (
      input  io_i_backend_redirect_valid,
      input  io_i_backend_redirect_target,
      input  io_i_branch_presolve_pack_valid,
      input  io_i_branch_presolve_pack_pc,
      input  io_i_fetch_req_ready,
      output io_o_fetch_req_valid,
      output io_o_fetch_req_pc,
      output io_o_flush
   );

   modport slave (
      output io_i_backend_redirect_valid,
      output io_i_backend_redirect_target,
      output io_i_branch_presolve_pack_valid,
      output io_i_branch_presolve_pack_pc,
      output io_i_fetch_req_ready,
      input  io_o_fetch_req_valid,
      input  io_o_fetch_req_pc,
      input  io_o_flush
   );

endinterface

// File: rtl/fetch_redirect_arbiter.sv
// Next-PC priority mux: backend redirect, then qualified presolve, then sequential advance.
module fetch_redirect_arbiter
   import fetch_pkg::*;
(
   input  logic         backend_valid,
   input  pc_t          backend_target,
   input  logic         presolve_valid,
   input  pc_t          presolve_pc,
   input  logic         fire,
   input  pc_t          pc_q,
   input  logic [2:0]   squash_cnt,
   input  fetch_state_t state,
   output pc_t          next_pc,
   output logic         redirect_taken
);

   always_comb begin
      next_pc        = pc_q;
      redirect_taken = 1'b0;
      if (backend_valid) begin
         next_pc        = backend_target;
         redirect_taken = 1'b1;
      end else if (presolve_valid && (squash_cnt == 3'd0) && (state == RUN)) begin
         next_pc        = presolve_pc;
         redirect_taken = 1'b1;
      end else if (fire) begin
         // Redirect targets stay unaligned; only the sequential step snaps to the fetch group.
         next_pc = fetch_align(pc_q) + pc_t'(FETCH_GROUP_BYTES);
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the fetch PC, squash window and flush pulse.
//   state | meaning
//   BOOT  | first cycle after reset, no fetch request, presolve ignored
//   RUN   | issuing fetch requests continuously
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter pc_t         RESET_PC      = 64'h0000_0000_8000_0000,
   parameter int unsigned SQUASH_CYCLES = 2
)(
   input  logic          clock,
   input  logic          reset,
   fetch_pc_gen_if.master bus
);

   localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES);

   fetch_state_t state;
   pc_t          pc_q;
   pc_t          next_pc;
   logic [2:0]   squash_cnt;
   logic         flush_q;
   logic         req_valid_q;
   logic         redirect_taken;
   logic         fire;

   assign fire = req_valid_q & bus.io_i_fetch_req_ready;

   fetch_redirect_arbiter u_arbiter (
      .backend_valid  (bus.io_i_backend_redirect_valid),
      .backend_target (bus.io_i_backend_redirect_target),
      .presolve_valid (bus.io_i_branch_presolve_pack_valid),
      .presolve_pc    (bus.io_i_branch_presolve_pack_pc),
      .fire           (fire),
      .pc_q           (pc_q),
      .squash_cnt     (squash_cnt),
      .state          (state),
      .next_pc        (next_pc),
      .redirect_taken (redirect_taken)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= BOOT;
         req_valid_q <= 1'b0;
         pc_q        <= RESET_PC;
         squash_cnt  <= 3'd0;
         flush_q     <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state       <= RUN;
               req_valid_q <= 1'b1;
            end
            RUN: begin
               state       <= RUN;
               req_valid_q <= 1'b1;
            end
         endcase
         pc_q    <= next_pc;
         flush_q <= redirect_taken;
         if (bus.io_i_backend_redirect_valid)
            squash_cnt <= SQUASH_LOAD;
         else if (squash_cnt != 3'd0)
            squash_cnt <= squash_cnt - 3'd1;
      end
   end

   assign bus.io_o_fetch_req_valid = req_valid_q;
   assign bus.io_o_fetch_req_pc    = pc_q;
   assign bus.io_o_flush           = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed and randomized bench for fetch_pc_gen against a cycle-indexed reference model.
module tb_fetch_pc_gen;
   import fetch_pkg::*;

   localparam pc_t RST_PC = 64'h0000_0000_8000_0000;
   localparam int  SQ     = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;

   fetch_pc_gen_if bus ();

   fetch_pc_gen #(.RESET_PC(RST_PC), .SQUASH_CYCLES(SQ)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: squash is "within SQ edges after the last backend redirect edge".
   logic [63:0] m_pc;
   bit          m_run;
   bit          m_flush;
   bit          m_have_be;
   longint      cyc;
   longint      m_last_be;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc      = RST_PC;
      m_run     = 0;
      m_flush   = 0;
      m_have_be = 0;
      cyc       = 0;
      m_last_be = 0;
   endtask

   task automatic drive(input bit bv, input pc_t bt, input bit pv, input pc_t pp, input bit rdy);
      bus.io_i_backend_redirect_valid     = bv;
      bus.io_i_backend_redirect_target    = bt;
      bus.io_i_branch_presolve_pack_valid = pv;
      bus.io_i_branch_presolve_pack_pc    = pp;
      bus.io_i_fetch_req_ready            = rdy;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_valid"}, 64'(bus.io_o_fetch_req_valid), 64'(m_run));
      chk({tag, "_pc"},    bus.io_o_fetch_req_pc,         m_pc);
      chk({tag, "_flush"}, 64'(bus.io_o_flush),           64'(m_flush));
   endtask

   task automatic step(input string tag);
      bit squashed;
      bit fire;
      @(posedge clock);
      fire     = m_run && bus.io_i_fetch_req_ready;
      squashed = m_have_be && ((cyc - m_last_be) <= SQ);
      if (bus.io_i_backend_redirect_valid) begin
         m_pc      = bus.io_i_backend_redirect_target;
         m_flush   = 1;
         m_have_be = 1;
         m_last_be = cyc;
      end else if (bus.io_i_branch_presolve_pack_valid && m_run && !squashed) begin
         m_pc    = bus.io_i_branch_presolve_pack_pc;
         m_flush = 1;
      end else begin
         if (fire) m_pc = (m_pc / 8) * 8 + 8;
         m_flush = 0;
      end
      m_run = 1;
      cyc++;
      #1;
      check_outputs(tag);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_valid"}, 64'(bus.io_o_fetch_req_valid), 64'd0);
      chk({tag, "_pc"},    bus.io_o_fetch_req_pc,         RST_PC);
      chk({tag, "_flush"}, 64'(bus.io_o_flush),           64'd0);
   endtask

   initial begin
      pc_t t;
      drive(0, '0, 0, '0, 1);
      model_reset();
      #12 reset = 1'b1;
      #1 check_reset_values("reset");

      // Sequential fetch with ready held high
      step("boot");
      chk("seq0", bus.io_o_fetch_req_pc, 64'h8000_0000);
      step("seq1");
      chk("seq1c", bus.io_o_fetch_req_pc, 64'h8000_0008);
      step("seq2");
      chk("seq2c", bus.io_o_fetch_req_pc, 64'h8000_0010);

      // Stall
      drive(0, '0, 0, '0, 0);
      for (int i = 0; i < 3; i++) step("stall");
      chk("stall_hold", bus.io_o_fetch_req_pc, 64'h8000_0010);
      drive(0, '0, 0, '0, 1);
      step("unstall");
      chk("unstall_c", bus.io_o_fetch_req_pc, 64'h8000_0018);

      // Unaligned presolve target, then aligned increment
      drive(0, '0, 1, 64'h8000_0104, 1);
      step("presolve");
      chk("presolve_c", bus.io_o_fetch_req_pc, 64'h8000_0104);
      chk("presolve_flush", 64'(bus.io_o_flush), 64'd1);
      drive(0, '0, 0, '0, 1);
      step("post_presolve");
      chk("post_presolve_c", bus.io_o_fetch_req_pc, 64'h8000_0108);

      // Backend beats simultaneous presolve, then squash window
      drive(1, 64'h9000_0000, 1, 64'h8000_0200, 1);
      step("backend");
      chk("backend_c", bus.io_o_fetch_req_pc, 64'h9000_0000);
      drive(0, '0, 1, 64'h8000_0300, 0);
      step("squash1");
      chk("squash1_flush", 64'(bus.io_o_flush), 64'd0);
      step("squash2");
      chk("squash2_pc", bus.io_o_fetch_req_pc, 64'h9000_0000);
      step("squash_end");
      chk("squash_end_c", bus.io_o_fetch_req_pc, 64'h8000_0300);

      // 64-bit wrap of the sequential advance
      drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0, 1);
      step("wrap_redir");
      drive(0, '0, 0, '0, 1);
      step("wrap");
      chk("wrap_c", bus.io_o_fetch_req_pc, 64'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         t = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom()} : {$urandom(), $urandom()};
         drive(($urandom_range(0, 9) == 0), t,
               ($urandom_range(0, 3) == 0), {$urandom(), $urandom()},
               ($urandom_range(0, 2) != 0));
         step("rand");
      end

      // Asynchronous reset mid-stall with a redirect pending
      drive(1, 64'hA000_0000, 0, '0, 0);
      #3 reset = 1'b0;
      #1 check_reset_values("async_rst");
      model_reset();
      @(posedge clock);
      #1 check_reset_values("held_rst");

      // Presolve during BOOT is dropped
      drive(0, '0, 1, 64'hB000_0004, 0);
      #2 reset = 1'b1;
      step("boot_presolve");
      chk("boot_presolve_flush", 64'(bus.io_o_flush), 64'd0);

      // Backend during BOOT is honoured
      #2 reset = 1'b0;
      #1 model_reset();
      drive(1, 64'hC000_0000, 0, '0, 1);
      #2 reset = 1'b1;
      step("boot_backend");
      chk("boot_backend_c", bus.io_o_fetch_req_pc, 64'hC000_0000);
      drive(0, '0, 0, '0, 1);
      step("after_boot_backend");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Front-end fetch PC generator: the consumer of the branch presolve pack, sitting upstream of the instruction cache request port. It holds the architectural fetch PC and issues 8-byte-aligned fetch requests over a valid/ready handshake. It takes redirects from the backend (mispredict/exception) and from branch presolve, with backend priority. A squash window drops presolve redirects belonging to wrong-path fetch packs.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- SQUASH_CYCLES, 2, number of cycles after a backend redirect during which presolve redirects are discarded (1..7).

Ports:
- clock  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- io_i_backend_redirect_valid  input  1  backend redirect request.
- io_i_backend_redirect_target  input  64  backend redirect target PC.
- io_i_branch_presolve_pack_valid  input  1  presolve redirect request.
- io_i_branch_presolve_pack_pc  input  64  presolve redirect target PC.
- io_i_fetch_req_ready  input  1  icache accepts the request this cycle.
- io_o_fetch_req_valid  output  1  fetch request valid.
- io_o_fetch_req_pc  output  64  fetch PC, driven straight from pc_q.
- io_o_flush  output  1  one-cycle pulse: kill in-flight fetch packs.

## Operation
- State machine: BOOT, RUN.
  - BOOT is entered on reset; req_valid=0.
  - BOOT -> RUN at the first rising edge after reset deasserts, unconditionally.
  - RUN never returns to BOOT except via reset.
- Registers: pc_q, state, squash_cnt (3 bits), flush_q.
- Priority of next pc_q:
  - Backend redirect valid: load backend_target.
  - Else presolve valid, squash_cnt==0 and state==RUN: load presolve_pc.
  - Else fire (req_valid & ready): load {pc_q[63:3],3'b0} + 8.
  - Else hold.
- Redirects are honoured whether or not the request fires. This is the one permitted change of req_pc while req_valid is high without a handshake.
- Backend redirect in BOOT is honoured. Presolve in BOOT is ignored.
- Redirect targets are loaded unaligned as given; alignment is applied only on the sequential increment. The request PC itself is not masked.
- Sequential arithmetic is 64-bit modulo. 64'hFFFF_FFFF_FFFF_FFF8 + 8 wraps to 0.
- squash_cnt:
  - Loaded with SQUASH_CYCLES on a backend redirect.
  - Otherwise decrements when nonzero, saturating at 0.
  - A backend redirect while the counter is nonzero reloads it.
- flush_q is set the cycle after any honoured redirect (backend or presolve) and cleared otherwise.
- A discarded presolve (squashed or in BOOT) produces no flush.

## Timing
- Reset values: pc_q=RESET_PC, state=BOOT, squash_cnt=0, flush_q=0. Outputs: req_valid=0, req_pc=RESET_PC, flush=0.
- Reset assertion mid-operation forces all registers to reset values asynchronously, regardless of in-flight handshakes.
- Redirect latency: redirect at cycle t gives req_pc=target and flush=1 at t+1.
- Sequential advance: fire at cycle t gives req_pc=aligned+8 at t+1.
- No combinational path from any input to any output; all outputs are registered.
- Squash window, backend redirect at t:
  - Presolve inputs at t+1 .. t+SQUASH_CYCLES are ignored.
  - A presolve at t+SQUASH_CYCLES+1 is honoured.
- Simultaneous events:
  - Backend and presolve together: backend wins, presolve dropped.
  - Fire with either redirect: the redirect wins. The accepted request is still counted by the icache; flush kills its response.

## Structure
- Shared package fetch_pkg:
  - FETCH_GROUP_BYTES=8 and FETCH_ALIGN_BITS=3.
  - fetch_state_t enum {BOOT, RUN}.
  - 64-bit PC typedef pc_t.
  - These constants are reused by branch presolve and icache.
- One sub-module: fetch_redirect_arbiter. Combinational priority mux producing next_pc and a redirect_taken strobe from the backend/presolve/sequential sources plus the squash and state qualifiers.
- The top holds the registers and the squash counter.

## Test plan
- Reset release, ready=1 throughout:
  - req_valid=0 in the first cycle.
  - Then req_pc = 0x80000000, 0x80000008, 0x80000010 on successive cycles; flush stays 0.
- ready=0 for 3 cycles at pc 0x80000010: req_pc holds 0x80000010 with req_valid=1. On ready=1 it advances to 0x80000018.
- Presolve valid with pc=0x80000104 at t (unaligned target): req_pc=0x80000104 and flush=1 at t+1. After a fire, next req_pc=0x80000108.
- Backend redirect to 0x90000000 at t together with presolve pc 0x80000200:
  - req_pc=0x90000000 at t+1.
  - Presolves at t+1 and t+2 are ignored with no flush.
  - A presolve at t+3 is honoured.
- Wrap: backend redirect to 0xFFFF_FFFF_FFFF_FFFC, then fire: req_pc=0.
- Reset asserted mid-stall with a redirect pending: outputs immediately return to reset values (req_valid=0, req_pc=RESET_PC, flush=0).
